// File: rtl/coinc_pkg.sv
// Shared defaults and FSM encoding for the coincidence gate counter.
package coinc_pkg;
    localparam int CNT_W_DEF  = 24;
    localparam int GATE_W_DEF = 32;
    localparam int WIN_W_DEF  = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GATE = 1'b1;
endpackage

// File: rtl/coinc_window.sv
// Per-channel coincidence window: stays open for len cycles after a start pulse.
module coinc_window
    import coinc_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [WIN_W-1:0] len,
    output logic             open
);
    localparam logic [WIN_W-1:0] WIN_ONE = 1;

    logic [WIN_W-1:0] rem_q, rem_d;

    always_comb begin
        rem_d = rem_q;
        if (clear)
            rem_d = '0;
        else if (start)
            rem_d = len;
        else if (rem_q != '0)
            rem_d = rem_q - WIN_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) rem_q <= '0;
        else       rem_q <= rem_d;
    end

    assign open = (rem_q != '0);
endmodule

// File: rtl/coincidence_gate_counter.sv
// Gated A/B/coincidence event counter with back-to-back gates and a
// valid/ack result handshake with sticky overrun.
module coincidence_gate_counter
    import coinc_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF,
    parameter int WIN_W  = WIN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_a,
    input  logic              pulse_b,
    input  logic              run,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [WIN_W-1:0]  win_len,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic [CNT_W-1:0]  count_c,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              overrun
);
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [GATE_W-1:0] GATE_ONE = 1;

    logic [0:0]        state_q, state_d;
    logic [GATE_W-1:0] cyc_q, cyc_d, len_q, len_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  wa_q, wa_d, wb_q, wb_d, wc_q, wc_d;
    logic [CNT_W-1:0]  na, nb, nc;
    logic [CNT_W-1:0]  oa_q, oa_d, ob_q, ob_d, oc_q, oc_d;
    logic              valid_q, valid_d, ovr_q, ovr_d;
    logic              counting, gate_end, gate_start, coinc;
    logic              open_a, open_b, clr_win;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + CNT_ONE : v;
    endfunction

    assign counting   = (state_q == ST_GATE) && run;
    assign gate_end   = counting && (cyc_q == len_q - GATE_ONE);
    assign gate_start = ((state_q == ST_IDLE) && run) || gate_end;
    assign coinc      = counting && ((pulse_a && pulse_b) || (pulse_a && open_b) || (pulse_b && open_a));
    // Windows are held shut outside a running gate and wiped at each gate boundary.
    assign clr_win    = !counting || gate_end || coinc;

    coinc_window #(.WIN_W(WIN_W)) u_win_a (
        .clk(clk), .reset(reset), .clear(clr_win),
        .start(counting && pulse_a && !coinc), .len(win_q), .open(open_a)
    );
    coinc_window #(.WIN_W(WIN_W)) u_win_b (
        .clk(clk), .reset(reset), .clear(clr_win),
        .start(counting && pulse_b && !coinc), .len(win_q), .open(open_b)
    );

    always_comb begin
        na = sat_inc(wa_q, counting && pulse_a);
        nb = sat_inc(wb_q, counting && pulse_b);
        nc = sat_inc(wc_q, coinc);

        state_d = run ? ST_GATE : ST_IDLE;
        cyc_d   = gate_start ? '0 : (counting ? cyc_q + GATE_ONE : cyc_q);
        len_d   = len_q;
        win_d   = win_q;
        if (gate_start) begin
            len_d = (gate_len == '0) ? GATE_ONE : gate_len;
            win_d = win_len;
        end
        wa_d = gate_start ? '0 : na;
        wb_d = gate_start ? '0 : nb;
        wc_d = gate_start ? '0 : nc;

        oa_d    = oa_q;
        ob_d    = ob_q;
        oc_d    = oc_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        // Totals include the final gate cycle, hence the next-value counts.
        if (gate_end) begin
            if (!valid_q || data_ack) begin
                oa_d    = na;
                ob_d    = nb;
                oc_d    = nc;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            len_q   <= GATE_ONE;
            win_q   <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            wc_q    <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            oc_q    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            len_q   <= len_d;
            win_q   <= win_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            wc_q    <= wc_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            oc_q    <= oc_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign count_a    = oa_q;
    assign count_b    = ob_q;
    assign count_c    = oc_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_coincidence_gate_counter.sv
// Randomized and directed bench for coincidence_gate_counter against a
// timestamp-based reference model; a CNT_W=4 copy checks saturation.
module tb_coincidence_gate_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pulse_a = 1'b0, pulse_b = 1'b0, run = 1'b0, data_ack = 1'b0;
    logic [31:0] gate_len = 32'd1;
    logic [3:0]  win_len = 4'd0;
    logic [23:0] count_a, count_b, count_c;
    logic [3:0]  c4_a, c4_b, c4_c;
    logic        data_valid, overrun, v4, o4;

    int n_tests = 0, n_fail = 0;

    // reference model state
    bit active = 0;
    int t = 0, L = 1, W = 0, na = 0, nb = 0, nc = 0, last_a = -1, last_b = -1;
    int e_ca = 0, e_cb = 0, e_cc = 0, e4_ca = 0, e4_cb = 0, e4_cc = 0;
    bit e_v = 0, e_o = 0;

    coincidence_gate_counter dut (
        .clk(clk), .reset(reset), .pulse_a(pulse_a), .pulse_b(pulse_b), .run(run),
        .gate_len(gate_len), .win_len(win_len), .count_a(count_a), .count_b(count_b),
        .count_c(count_c), .data_valid(data_valid), .data_ack(data_ack), .overrun(overrun)
    );

    coincidence_gate_counter #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .pulse_a(pulse_a), .pulse_b(pulse_b), .run(run),
        .gate_len(gate_len), .win_len(win_len), .count_a(c4_a), .count_b(c4_b),
        .count_c(c4_c), .data_valid(v4), .data_ack(data_ack), .overrun(o4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        bit gend, hit;
        if (reset) begin
            active = 0;
            e_ca = 0; e_cb = 0; e_cc = 0; e4_ca = 0; e4_cb = 0; e4_cc = 0;
            e_v = 0; e_o = 0;
            return;
        end
        gend = 0;
        if (active && run) begin
            if (pulse_a) na++;
            if (pulse_b) nb++;
            hit = (pulse_a && pulse_b) ||
                  (pulse_a && last_b >= 0 && t - last_b <= W) ||
                  (pulse_b && last_a >= 0 && t - last_a <= W);
            if (hit) begin
                nc++; last_a = -1; last_b = -1;
            end else begin
                if (pulse_a) last_a = t;
                if (pulse_b) last_b = t;
            end
            if (t == L - 1) gend = 1;
            else t++;
        end
        if (gend) begin
            if (!e_v || data_ack) begin
                e_ca = sat(na, 24'hFFFFFF); e_cb = sat(nb, 24'hFFFFFF); e_cc = sat(nc, 24'hFFFFFF);
                e4_ca = sat(na, 15); e4_cb = sat(nb, 15); e4_cc = sat(nc, 15);
                e_v = 1;
            end else begin
                e_o = 1;
            end
        end else if (e_v && data_ack) begin
            e_v = 0;
        end
        if (run && (!active || gend)) begin
            active = 1; t = 0;
            L = (gate_len == 0) ? 1 : int'(gate_len);
            W = int'(win_len);
            na = 0; nb = 0; nc = 0; last_a = -1; last_b = -1;
        end else if (!run) begin
            active = 0;
        end
    endtask

    task automatic cyc(input logic a, input logic b);
        pulse_a = a;
        pulse_b = b;
        @(posedge clk);
        model_step();
        #1;
        chk("valid", data_valid, e_v);
        chk("overrun", overrun, e_o);
        chk("count_a", count_a, e_ca);
        chk("count_b", count_b, e_cb);
        chk("count_c", count_c, e_cc);
        chk("c4_a", c4_a, e4_ca);
        chk("c4_b", c4_b, e4_cb);
        chk("c4_c", c4_c, e4_cc);
    endtask

    // Runs one gate whose start edge has already been taken.
    task automatic one_gate(input int len, input logic [127:0] av, input logic [127:0] bv,
                            input bit ack_last);
        for (int i = 0; i < len; i++) begin
            data_ack = ack_last && (i == len - 1);
            cyc(av[i], bv[i]);
        end
        data_ack = 0;
    endtask

    task automatic stop_and_ack();
        run = 0; data_ack = 1;
        cyc(0, 0);
        data_ack = 0;
    endtask

    initial begin
        logic [127:0] av, bv;

        reset = 1;
        cyc(0, 0); cyc(0, 0);
        reset = 0;
        cyc(0, 0);

        // 100-cycle gate, window 3
        gate_len = 100; win_len = 3; run = 1;
        cyc(0, 0);
        av = '0; bv = '0; av[10] = 1; av[50] = 1; bv[12] = 1; bv[80] = 1;
        one_gate(100, av, bv, 0);
        chk("g100_a", count_a, 2);
        chk("g100_b", count_b, 2);
        chk("g100_c", count_c, 1);
        chk("g100_valid", data_valid, 1);
        stop_and_ack();

        // window 0: only same-cycle pulses coincide
        gate_len = 30; win_len = 0; run = 1;
        cyc(0, 0);
        av = '0; bv = '0; av[5] = 1; bv[5] = 1; av[20] = 1; bv[21] = 1;
        one_gate(30, av, bv, 0);
        chk("w0_c", count_c, 1);
        stop_and_ack();

        // last cycle of one gate vs first cycle of the next
        gate_len = 10; win_len = 2; run = 1;
        cyc(0, 0);
        av = '0; bv = '0; av[9] = 1;
        one_gate(10, av, bv, 0);
        chk("edge1_a", count_a, 1);
        chk("edge1_b", count_b, 0);
        av = '0; bv = '0; av[0] = 1; bv[3] = 1;
        one_gate(10, av, bv, 1);
        chk("edge2_a", count_a, 1);
        chk("edge2_b", count_b, 1);
        chk("edge2_ovr", overrun, 0);
        stop_and_ack();

        // saturation
        gate_len = 25; win_len = 1; run = 1;
        cyc(0, 0);
        av = '0; bv = '0;
        for (int i = 0; i < 20; i++) av[i] = 1;
        one_gate(25, av, bv, 0);
        chk("sat4_a", c4_a, 15);
        chk("sat24_a", count_a, 20);
        stop_and_ack();

        // overrun then recovery with ack on gate end
        gate_len = 8; win_len = 1; run = 1;
        cyc(0, 0);
        av = '0; bv = '0; av[1] = 1;
        one_gate(8, av, bv, 0);
        av[2] = 1;
        one_gate(8, av, bv, 0);
        chk("ovr_held_a", count_a, 1);
        chk("ovr_flag", overrun, 1);
        run = 0;
        cyc(0, 0);
        reset = 1;
        cyc(0, 0);
        reset = 0; run = 1;
        cyc(0, 0);
        av = '0; av[1] = 1;
        one_gate(8, av, bv, 0);
        av[2] = 1;
        one_gate(8, av, bv, 1);
        chk("ack_end_a", count_a, 2);
        chk("ack_end_ovr", overrun, 0);
        chk("ack_end_valid", data_valid, 1);
        stop_and_ack();

        // run low mid-gate: no result, outputs unchanged
        gate_len = 5; win_len = 1; run = 1;
        cyc(0, 0);
        av = '0; bv = '0; av[2] = 1;
        one_gate(5, av, bv, 0);
        stop_and_ack();
        gate_len = 100; run = 1;
        cyc(0, 0);
        for (int i = 0; i < 40; i++) cyc(i % 7 == 0, i % 5 == 0);
        run = 0;
        cyc(1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0);
        chk("abort_valid", data_valid, 0);
        chk("abort_a", count_a, 1);
        chk("abort_b", count_b, 0);

        // reset mid-gate
        run = 1;
        cyc(0, 0);
        for (int i = 0; i < 40; i++) cyc(i % 3 == 0, i % 4 == 0);
        reset = 1;
        cyc(1, 0);
        reset = 0; run = 0;
        cyc(0, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_a", count_a, 0);
        chk("rst_ovr", overrun, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom % 400) == 0;
            run      = ($urandom % 30) != 0;
            data_ack = ($urandom % 4) == 0;
            gate_len = $urandom_range(0, 20);
            win_len  = 4'($urandom_range(0, 5));
            cyc(($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
